// File: rtl/ldpc_syndrome_accum.sv
// ---------------------------------------------------------------------------
// ldpc_syndrome_accum
//
// Purpose:
//   Sits behind the quasi-cyclic shift network. Every accepted block is a
//   rotated Z-bit hard-decision slice for one non-zero base-matrix entry.
//   Blocks of one base-matrix row are XOR-accumulated into a Z-bit row
//   syndrome. That syndrome is presented on a valid/ready output one cycle
//   after the row's last block. Per frame the block counts the rows with a
//   non-zero syndrome. When the frame's last row syndrome is popped, it
//   reports whether the whole codeword checks.
//
// Ports:
//   clk           in   1      rising-edge clock
//   rst           in   1      synchronous active-high reset
//   in_valid      in   1      input block valid
//   in_ready      out  1      block accepted when in_valid & in_ready
//   in_data       in   Z      rotated block
//   in_last_col   in   1      last non-zero block of the current row
//   in_last_row   in   1      current row closes the frame (with in_last_col)
//   out_valid     out  1      row syndrome available
//   out_ready     in   1      consumer takes the row syndrome
//   out_syndrome  out  Z      XOR of all blocks of the row
//   out_row_idx   out  ROW_W  row index of out_syndrome
//   out_last      out  1      syndrome belongs to the frame's last row
//   frame_done    out  1      one-cycle pulse after the last-row syndrome pops
//   frame_ok      out  1      all row syndromes of the closed frame were zero
//   unsat_cnt     out  ROW_W  non-zero row syndromes in the closed frame
//   frame_err     out  1      sticky row-sequencing error, cleared by rst
// ---------------------------------------------------------------------------
module ldpc_syndrome_accum #(
    parameter int LIFTING_FACTOR = 4,
    parameter int ROWS           = 3,
    parameter int ROW_W          = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LIFTING_FACTOR-1:0] in_data,
    input  logic                      in_last_col,
    input  logic                      in_last_row,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LIFTING_FACTOR-1:0] out_syndrome,
    output logic [ROW_W-1:0]          out_row_idx,
    output logic                      out_last,
    output logic                      frame_done,
    output logic                      frame_ok,
    output logic [ROW_W-1:0]          unsat_cnt,
    output logic                      frame_err
);

    localparam logic [ROW_W-1:0] LAST_ROW_IDX = ROW_W'(ROWS - 1);
    localparam logic [ROW_W-1:0] CNT_MAX      = '1;

    logic [LIFTING_FACTOR-1:0] acc_q, acc_d;
    logic                      row_open_q, row_open_d;
    logic [ROW_W-1:0]          row_idx_q, row_idx_d;
    logic                      out_valid_q, out_valid_d;
    logic [LIFTING_FACTOR-1:0] out_syndrome_q, out_syndrome_d;
    logic [ROW_W-1:0]          out_row_idx_q, out_row_idx_d;
    logic                      out_last_q, out_last_d;
    logic                      frame_done_q, frame_done_d;
    logic                      frame_ok_q, frame_ok_d;
    logic [ROW_W-1:0]          unsat_cnt_q, unsat_cnt_d;
    logic                      frame_err_q, frame_err_d;
    logic                      ok_acc_q, ok_acc_d;
    logic [ROW_W-1:0]          unsat_acc_q, unsat_acc_d;

    logic                      beat;
    logic                      pop;
    logic [LIFTING_FACTOR-1:0] row_syn;
    logic                      syn_nz;
    logic                      ok_base;
    logic [ROW_W-1:0]          unsat_base;

    // Syndrome including the current block. A closed row contributes
    // nothing, so the first block of a row starts from zero.
    genvar gi;
    generate
        for (gi = 0; gi < LIFTING_FACTOR; gi++) begin : g_lane
            assign row_syn[gi] = (row_open_q & acc_q[gi]) ^ in_data[gi];
        end
    endgenerate

    assign syn_nz   = |row_syn;
    assign pop      = out_valid_q & out_ready;
    assign in_ready = !out_valid_q | out_ready;
    assign beat     = in_valid & in_ready;

    always_comb begin
        acc_d          = acc_q;
        row_open_d     = row_open_q;
        row_idx_d      = row_idx_q;
        out_valid_d    = out_valid_q;
        out_syndrome_d = out_syndrome_q;
        out_row_idx_d  = out_row_idx_q;
        out_last_d     = out_last_q;
        frame_done_d   = 1'b0;
        frame_ok_d     = frame_ok_q;
        unsat_cnt_d    = unsat_cnt_q;
        frame_err_d    = frame_err_q;
        ok_base        = ok_acc_q;
        unsat_base     = unsat_acc_q;

        if (pop) begin
            out_valid_d = 1'b0;
        end

        // Popping the last row publishes the totals and restarts the
        // accumulators. A row closing in this same cycle therefore lands in
        // the fresh frame.
        if (pop && out_last_q) begin
            frame_done_d = 1'b1;
            frame_ok_d   = ok_acc_q;
            unsat_cnt_d  = unsat_acc_q;
            ok_base      = 1'b1;
            unsat_base   = '0;
        end

        ok_acc_d    = ok_base;
        unsat_acc_d = unsat_base;

        if (beat) begin
            if (!in_last_col) begin
                acc_d      = row_syn;
                row_open_d = 1'b1;
            end else begin
                out_valid_d    = 1'b1;
                out_syndrome_d = row_syn;
                out_row_idx_d  = row_idx_q;
                out_last_d     = in_last_row;
                acc_d          = '0;
                row_open_d     = 1'b0;
                ok_acc_d       = ok_base & !syn_nz;
                if (syn_nz && (unsat_base != CNT_MAX)) begin
                    unsat_acc_d = unsat_base + 1'b1;
                end

                // Row sequencing: the frame's last row must be row ROWS-1.
                // A mismatch either way is flagged, and indexing restarts at 0.
                if (in_last_row) begin
                    row_idx_d = '0;
                    if (row_idx_q != LAST_ROW_IDX) begin
                        frame_err_d = 1'b1;
                    end
                end else if (row_idx_q == LAST_ROW_IDX) begin
                    row_idx_d   = '0;
                    frame_err_d = 1'b1;
                end else begin
                    row_idx_d = row_idx_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q          <= '0;
            row_open_q     <= 1'b0;
            row_idx_q      <= '0;
            out_valid_q    <= 1'b0;
            out_syndrome_q <= '0;
            out_row_idx_q  <= '0;
            out_last_q     <= 1'b0;
            frame_done_q   <= 1'b0;
            frame_ok_q     <= 1'b0;
            unsat_cnt_q    <= '0;
            frame_err_q    <= 1'b0;
            ok_acc_q       <= 1'b1;
            unsat_acc_q    <= '0;
        end else begin
            acc_q          <= acc_d;
            row_open_q     <= row_open_d;
            row_idx_q      <= row_idx_d;
            out_valid_q    <= out_valid_d;
            out_syndrome_q <= out_syndrome_d;
            out_row_idx_q  <= out_row_idx_d;
            out_last_q     <= out_last_d;
            frame_done_q   <= frame_done_d;
            frame_ok_q     <= frame_ok_d;
            unsat_cnt_q    <= unsat_cnt_d;
            frame_err_q    <= frame_err_d;
            ok_acc_q       <= ok_acc_d;
            unsat_acc_q    <= unsat_acc_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_syndrome = out_syndrome_q;
    assign out_row_idx  = out_row_idx_q;
    assign out_last     = out_last_q;
    assign frame_done   = frame_done_q;
    assign frame_ok     = frame_ok_q;
    assign unsat_cnt    = unsat_cnt_q;
    assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_ldpc_syndrome_accum.sv
// ---------------------------------------------------------------------------
// tb_ldpc_syndrome_accum
//
// Purpose:
//   Directed bench for ldpc_syndrome_accum with Z=4 and ROWS=3. A vector
//   table holds per-cycle inputs and the outputs expected during that same
//   cycle. Short hand-written sequences cover backpressure and a mid-row
//   reset.
// ---------------------------------------------------------------------------
module tb_ldpc_syndrome_accum;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       in_last_col;
    logic       in_last_row;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_syndrome;
    logic [1:0] out_row_idx;
    logic       out_last;
    logic       frame_done;
    logic       frame_ok;
    logic [1:0] unsat_cnt;
    logic       frame_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ldpc_syndrome_accum #(
        .LIFTING_FACTOR(4),
        .ROWS          (3),
        .ROW_W         (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last_col (in_last_col),
        .in_last_row (in_last_row),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_syndrome(out_syndrome),
        .out_row_idx (out_row_idx),
        .out_last    (out_last),
        .frame_done  (frame_done),
        .frame_ok    (frame_ok),
        .unsat_cnt   (unsat_cnt),
        .frame_err   (frame_err)
    );

    // Inputs applied in a cycle and the outputs expected in that same cycle
    // (i.e. the state left by earlier cycles; out_ready is held at 1).
    typedef struct {
        logic       v;
        logic [3:0] d;
        logic       lc;
        logic       lr;
        logic       e_ov;
        logic [3:0] e_syn;
        logic [1:0] e_idx;
        logic       e_last;
        logic       e_fd;
        logic       e_fok;
        logic [1:0] e_unsat;
        logic       e_err;
    } vec_t;

    localparam int NVEC = 23;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic v, input logic [3:0] d, input logic lc,
                                input logic lr, input logic ov, input logic [3:0] syn,
                                input logic [1:0] idx, input logic last, input logic fd,
                                input logic fok, input logic [1:0] u, input logic err);
        vec_t r;
        r.v = v; r.d = d; r.lc = lc; r.lr = lr;
        r.e_ov = ov; r.e_syn = syn; r.e_idx = idx; r.e_last = last;
        r.e_fd = fd; r.e_fok = fok; r.e_unsat = u; r.e_err = err;
        return r;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Apply one cycle of input, then sit at the falling edge for sampling.
    task automatic step(input logic v, input logic [3:0] d, input logic lc,
                        input logic lr, input logic rdy);
        @(posedge clk);
        #1;
        in_valid    = v;
        in_data     = d;
        in_last_col = lc;
        in_last_row = lr;
        out_ready   = rdy;
        @(negedge clk);
    endtask

    task automatic chk_outs(input string tag, input logic ov, input logic [3:0] syn,
                            input logic [1:0] idx, input logic last, input logic fd,
                            input logic fok, input logic [1:0] u, input logic err);
        chk({tag, " out_valid"},    8'(out_valid),    8'(ov));
        chk({tag, " out_syndrome"}, 8'(out_syndrome), 8'(syn));
        chk({tag, " out_row_idx"},  8'(out_row_idx),  8'(idx));
        chk({tag, " out_last"},     8'(out_last),     8'(last));
        chk({tag, " frame_done"},   8'(frame_done),   8'(fd));
        chk({tag, " frame_ok"},     8'(frame_ok),     8'(fok));
        chk({tag, " unsat_cnt"},    8'(unsat_cnt),    8'(u));
        chk({tag, " frame_err"},    8'(frame_err),    8'(err));
    endtask

    initial begin
        // Rows 0..2 of frame A: zero syndromes (test 1 row is row 0).
        vecs[0]  = mk(1, 4'b1010, 0, 0,  0, 4'b0000, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 4'b0110, 0, 0,  0, 4'b0000, 0, 0, 0, 0, 0, 0);
        vecs[2]  = mk(1, 4'b1100, 1, 0,  0, 4'b0000, 0, 0, 0, 0, 0, 0);
        vecs[3]  = mk(0, 4'b0000, 0, 0,  1, 4'b0000, 0, 0, 0, 0, 0, 0);
        vecs[4]  = mk(1, 4'b0001, 0, 0,  0, 4'b0000, 0, 0, 0, 0, 0, 0);
        vecs[5]  = mk(1, 4'b0001, 1, 0,  0, 4'b0000, 0, 0, 0, 0, 0, 0);
        vecs[6]  = mk(1, 4'b1111, 0, 0,  1, 4'b0000, 1, 0, 0, 0, 0, 0);
        vecs[7]  = mk(1, 4'b1111, 1, 1,  0, 4'b0000, 1, 0, 0, 0, 0, 0);
        vecs[8]  = mk(0, 4'b0000, 0, 0,  1, 4'b0000, 2, 1, 0, 0, 0, 0);
        vecs[9]  = mk(0, 4'b0000, 0, 0,  0, 4'b0000, 2, 1, 1, 1, 0, 0);
        // Frame B: single-block row 0, row 1 syndrome 0100, row 2 zero.
        vecs[10] = mk(1, 4'b0000, 1, 0,  0, 4'b0000, 2, 1, 0, 1, 0, 0);
        vecs[11] = mk(1, 4'b1000, 0, 0,  1, 4'b0000, 0, 0, 0, 1, 0, 0);
        vecs[12] = mk(1, 4'b1100, 1, 0,  0, 4'b0000, 0, 0, 0, 1, 0, 0);
        vecs[13] = mk(1, 4'b0011, 0, 0,  1, 4'b0100, 1, 0, 0, 1, 0, 0);
        vecs[14] = mk(1, 4'b0011, 1, 1,  0, 4'b0100, 1, 0, 0, 1, 0, 0);
        vecs[15] = mk(0, 4'b0000, 0, 0,  1, 4'b0000, 2, 1, 0, 1, 0, 0);
        // Frame C: closes early on row 1 (sequencing error), pop+beat overlap.
        vecs[16] = mk(1, 4'b0101, 1, 0,  0, 4'b0000, 2, 1, 1, 0, 1, 0);
        vecs[17] = mk(1, 4'b0010, 1, 1,  1, 4'b0101, 0, 0, 0, 0, 1, 0);
        vecs[18] = mk(0, 4'b0000, 0, 0,  1, 4'b0010, 1, 1, 0, 0, 1, 1);
        vecs[19] = mk(0, 4'b0000, 0, 0,  0, 4'b0010, 1, 1, 1, 0, 2, 1);
        // Frame D starts again at row 0; error flag stays set.
        vecs[20] = mk(1, 4'b1001, 1, 0,  0, 4'b0010, 1, 1, 0, 0, 2, 1);
        vecs[21] = mk(0, 4'b0000, 0, 0,  1, 4'b1001, 0, 0, 0, 0, 2, 1);
        vecs[22] = mk(0, 4'b0000, 0, 0,  0, 4'b1001, 0, 0, 0, 0, 2, 1);

        rst         = 1'b1;
        in_valid    = 1'b0;
        in_data     = 4'b0000;
        in_last_col = 1'b0;
        in_last_row = 1'b0;
        out_ready   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_outs("reset", 0, 4'b0000, 0, 0, 0, 0, 0, 0);
        chk("reset in_ready", 8'(in_ready), 8'd1);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            step(vecs[i].v, vecs[i].d, vecs[i].lc, vecs[i].lr, 1'b1);
            $display("vec %0d: v=%0b d=%b lc=%0b lr=%0b -> ov=%0b syn=%b idx=%0d last=%0b fd=%0b ok=%0b unsat=%0d err=%0b",
                     i, vecs[i].v, vecs[i].d, vecs[i].lc, vecs[i].lr, out_valid, out_syndrome,
                     out_row_idx, out_last, frame_done, frame_ok, unsat_cnt, frame_err);
            chk_outs($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_syn, vecs[i].e_idx,
                     vecs[i].e_last, vecs[i].e_fd, vecs[i].e_fok, vecs[i].e_unsat, vecs[i].e_err);
            chk($sformatf("vec%0d in_ready", i), 8'(in_ready), 8'd1);
        end

        // Backpressure: syndrome 0110 pending on row 1, consumer stalls.
        step(1, 4'b0110, 1, 0, 1);
        chk("bp accept in_ready", 8'(in_ready), 8'd1);
        for (int k = 0; k < 3; k++) begin
            step(1, 4'b0011, 0, 0, 0);
            $display("stall %0d: in_ready=%0b ov=%0b syn=%b idx=%0d", k, in_ready, out_valid,
                     out_syndrome, out_row_idx);
            chk($sformatf("stall%0d in_ready", k), 8'(in_ready), 8'd0);
            chk($sformatf("stall%0d out_valid", k), 8'(out_valid), 8'd1);
            chk($sformatf("stall%0d out_syndrome", k), 8'(out_syndrome), 8'b0110);
            chk($sformatf("stall%0d out_row_idx", k), 8'(out_row_idx), 8'd1);
            chk($sformatf("stall%0d out_last", k), 8'(out_last), 8'd0);
        end
        step(1, 4'b0011, 0, 0, 1);
        $display("release: in_ready=%0b ov=%0b", in_ready, out_valid);
        chk("release in_ready", 8'(in_ready), 8'd1);
        chk("release out_valid", 8'(out_valid), 8'd1);
        step(1, 4'b0101, 1, 1, 1);
        chk("bp next out_valid", 8'(out_valid), 8'd0);
        step(0, 4'b0000, 0, 0, 0);
        $display("bp row2: ov=%0b syn=%b idx=%0d last=%0b", out_valid, out_syndrome,
                 out_row_idx, out_last);
        chk_outs("bp row2", 1, 4'b0110, 2, 1, 0, 0, 2, 1);
        step(0, 4'b0000, 0, 0, 1);
        chk("bp pop out_valid", 8'(out_valid), 8'd1);
        step(0, 4'b0000, 0, 0, 1);
        $display("bp close: fd=%0b ok=%0b unsat=%0d", frame_done, frame_ok, unsat_cnt);
        chk_outs("bp close", 0, 4'b0110, 2, 1, 1, 0, 3, 1);

        // Reset in the middle of a row discards the partial accumulation.
        step(1, 4'b1111, 0, 0, 1);
        step(1, 4'b0001, 0, 0, 1);
        rst = 1'b1;
        step(0, 4'b0000, 0, 0, 1);
        rst = 1'b0;
        step(0, 4'b0000, 0, 0, 1);
        $display("mid-row reset: ov=%0b syn=%b err=%0b", out_valid, out_syndrome, frame_err);
        chk_outs("midrst", 0, 4'b0000, 0, 0, 0, 0, 0, 0);
        chk("midrst in_ready", 8'(in_ready), 8'd1);
        step(1, 4'b0100, 0, 0, 1);
        step(1, 4'b0010, 1, 0, 1);
        chk("post-rst out_valid before", 8'(out_valid), 8'd0);
        step(0, 4'b0000, 0, 0, 1);
        $display("post-reset row: ov=%0b syn=%b idx=%0d", out_valid, out_syndrome, out_row_idx);
        chk_outs("post-rst", 1, 4'b0110, 0, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
